// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared encodings and baud derivation for uart_frame_rx
package uart_frame_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_FILL = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

    localparam logic [1:0] BIT_IDLE  = 2'b00;
    localparam logic [1:0] BIT_START = 2'b01;
    localparam logic [1:0] BIT_DATA  = 2'b10;
    localparam logic [1:0] BIT_STOP  = 2'b11;

    localparam int FRAME_LEN_DEF = 800;

    function automatic int calc_baud_max(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver: 2-FF synchroniser, baud counter, bit FSM
// RX_GLITCH_FILTER_EN: each sample becomes a 2-of-3 vote over mid-1, mid, mid+1
module uart_rx_byte
    import uart_frame_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       rx_wire,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       stop_err
);

    localparam int BAUD_MAX = calc_baud_max(CLK_FREQ, UART_BPS);
    localparam int CW       = $clog2(BAUD_MAX + 1);
`ifdef RX_GLITCH_FILTER_EN
    localparam int VOTE_DLY = 1;
`else
    localparam int VOTE_DLY = 0;
`endif
    localparam logic [CW-1:0] START_CHK = CW'(BAUD_MAX / 2 + VOTE_DLY);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_MAX - 1);

    logic          rx_meta_q, rx_sync_q, rx_h1_q;
    logic [1:0]    bst_q, bst_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          byte_valid_q, byte_valid_d;
    logic          stop_err_q, stop_err_d;
    logic          rx_bit;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_h1_q   <= 1'b1;
        end else begin
            rx_meta_q <= rx_wire;
            rx_sync_q <= rx_meta_q;
            rx_h1_q   <= rx_sync_q;
        end
    end

`ifdef RX_GLITCH_FILTER_EN
    logic rx_h2_q;
    always_ff @(posedge sys_clk) begin
        if (!rst_n) rx_h2_q <= 1'b1;
        else        rx_h2_q <= rx_h1_q;
    end
    // Sampling one cycle late lets the vote include the sample after mid-bit.
    assign rx_bit = (rx_sync_q & rx_h1_q) | (rx_sync_q & rx_h2_q) | (rx_h1_q & rx_h2_q);
`else
    assign rx_bit = rx_sync_q;
`endif

    always_comb begin
        bst_d        = bst_q;
        cnt_d        = cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        byte_valid_d = 1'b0;
        stop_err_d   = 1'b0;
        case (bst_q)
            BIT_IDLE: begin
                cnt_d = '0;
                if (rx_h1_q && !rx_sync_q) bst_d = BIT_START;
            end
            BIT_START: begin
                if (cnt_q == START_CHK) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    bst_d     = rx_bit ? BIT_IDLE : BIT_DATA;
                end
            end
            BIT_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shreg_d   = {rx_bit, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) bst_d = BIT_STOP;
                end
            end
            default: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d        = '0;
                    bst_d        = BIT_IDLE;
                    byte_valid_d = rx_bit;
                    stop_err_d   = !rx_bit;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            bst_q        <= BIT_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            byte_valid_q <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            bst_q        <= bst_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            byte_valid_q <= byte_valid_d;
            stop_err_q   <= stop_err_d;
        end
    end

    assign byte_data  = shreg_q;
    assign byte_valid = byte_valid_q;
    assign stop_err   = stop_err_q;

endmodule

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - UART frame receiver: gap-resynchronised frame FSM and frame buffer
// RX_GLITCH_FILTER_EN is honoured inside uart_rx_byte
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int UART_BPS   = 115200,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int FRAME_LEN  = FRAME_LEN_DEF,
    parameter int GAP_CYCLES = 250_000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       rx_wire,
    input  logic [9:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       frame_valid,
    input  logic       frame_ack,
    output logic       frame_done,
    output logic       frame_err,
    output logic       overrun,
    output logic [1:0] state
);

    localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(FRAME_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic [7:0]    byte_data;
    logic          byte_valid, stop_err;

    logic [1:0]    st_q, st_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          frame_valid_q, frame_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    rd_data_q;
    logic [7:0]    mem_q [FRAME_LEN];

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) u_rx_byte (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .rx_wire    (rx_wire),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .stop_err   (stop_err)
    );

    always_comb begin
        st_d          = st_q;
        idx_d         = idx_q;
        gap_d         = '0;
        frame_valid_d = frame_valid_q;
        frame_done_d  = 1'b0;
        frame_err_d   = stop_err;
        overrun_d     = overrun_q;
        we            = 1'b0;
        waddr         = idx_q;
        case (st_q)
            ST_IDLE: begin
                idx_d = '0;
                if (byte_valid) begin
                    we    = 1'b1;
                    waddr = '0;
                    idx_d = AW'(1);
                    st_d  = ST_FILL;
                end
            end
            ST_FILL: begin
                if (byte_valid) begin
                    we = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        frame_done_d  = 1'b1;
                        frame_valid_d = 1'b1;
                        st_d          = ST_HOLD;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (stop_err) begin
                    idx_d = '0;
                    st_d  = ST_IDLE;
                end else if (gap_q == GAP_LAST) begin
                    frame_err_d = 1'b1;
                    idx_d       = '0;
                    st_d        = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_HOLD: begin
                // An ack releases the buffer first, so a coincident byte opens the next frame.
                if (frame_ack) begin
                    frame_valid_d = 1'b0;
                    overrun_d     = 1'b0;
                    idx_d         = '0;
                    st_d          = ST_IDLE;
                    if (byte_valid) begin
                        we    = 1'b1;
                        waddr = '0;
                        idx_d = AW'(1);
                        st_d  = ST_FILL;
                    end
                end else if (byte_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                idx_d = '0;
                st_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            st_q          <= ST_IDLE;
            idx_q         <= '0;
            gap_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            st_q          <= st_d;
            idx_q         <= idx_d;
            gap_q         <= gap_d;
            frame_valid_q <= frame_valid_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
        end
    end

    // Buffer contents survive reset; frame_valid alone says whether they are current.
    always_ff @(posedge sys_clk) begin
        if (we && rst_n) mem_q[waddr] <= byte_data;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n)                            rd_data_q <= '0;
        else if (int'(rd_addr) < FRAME_LEN)    rd_data_q <= mem_q[rd_addr[AW-1:0]];
        else                                   rd_data_q <= '0;
    end

    assign rd_data     = rd_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;
    assign state       = st_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - scoreboard bench for uart_frame_rx with a queue-based frame model
module tb_uart_frame_rx;

    localparam int CLK_FREQ = 1600;
    localparam int UART_BPS = 100;
    localparam int BAUD     = CLK_FREQ / UART_BPS;
    localparam int FLEN     = 16;
    localparam int GAP      = 600;
    localparam int SPACE    = 24;
    localparam int EV_DONE  = 1;
    localparam int EV_ERR   = 2;

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_wire = 1'b1;
    logic       frame_ack = 1'b0;
    logic [9:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       frame_valid, frame_done, frame_err, overrun;
    logic [1:0] state;

    int n_pass = 0;
    int n_total = 0;

    int         exp_ev[$];
    logic [7:0] cur_q[$];
    logic [7:0] held_q[$];
    bit         held = 1'b0;
    bit         ovr_exp = 1'b0;

    always #5 sys_clk = ~sys_clk;

    uart_frame_rx #(
        .UART_BPS   (UART_BPS),
        .CLK_FREQ   (CLK_FREQ),
        .FRAME_LEN  (FLEN),
        .GAP_CYCLES (GAP)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .rx_wire     (rx_wire),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .state       (state)
    );

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_ev.push_back(EV_ERR);
            if (!held) cur_q.delete();
        end else if (held) begin
            ovr_exp = 1'b1;
        end else begin
            cur_q.push_back(b);
            if (cur_q.size() == FLEN) begin
                held_q = cur_q;
                cur_q.delete();
                held = 1'b1;
                exp_ev.push_back(EV_DONE);
            end
        end
    endtask

    task automatic model_gap();
        if (!held && cur_q.size() > 0) begin
            exp_ev.push_back(EV_ERR);
            cur_q.delete();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good, input bit glitch);
        logic [9:0] bits;
        bits = {good, b, 1'b0};
        model_byte(b, good);
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < BAUD; c++) begin
                @(negedge sys_clk);
                rx_wire = (glitch && c == BAUD / 2 + 1) ? ~bits[i] : bits[i];
            end
        end
        @(negedge sys_clk);
        rx_wire = 1'b1;
        repeat (SPACE) @(negedge sys_clk);
    endtask

    task automatic send_random_frame();
        for (int i = 0; i < FLEN; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    endtask

    task automatic pulse_ack();
        @(negedge sys_clk);
        frame_ack = 1'b1;
        if (held) begin
            held    = 1'b0;
            ovr_exp = 1'b0;
        end
        @(negedge sys_clk);
        frame_ack = 1'b0;
    endtask

    task automatic read_chk(input int addr, input int exp, input string tag);
        @(negedge sys_clk);
        rd_addr = 10'(addr);
        @(negedge sys_clk);
        check($sformatf("%s rd[%0d]", tag, addr), int'(rd_data), exp);
    endtask

    task automatic check_frame(input string tag);
        check({tag, " frame_valid"}, int'(frame_valid), int'(held));
        check({tag, " state"}, int'(state), held ? 2 : 0);
        for (int a = 0; a < FLEN; a++) read_chk(a, int'(held_q[a]), tag);
    endtask

    always @(negedge sys_clk) begin
        int got;
        if (rst_n && (frame_done || frame_err)) begin
            got = frame_done ? EV_DONE : EV_ERR;
            if (exp_ev.size() == 0) check("unexpected event", got, 0);
            else                    check("event", got, exp_ev.pop_front());
        end
    end

    initial begin
        repeat (4) @(negedge sys_clk);
        check("reset state", int'(state), 0);
        check("reset frame_valid", int'(frame_valid), 0);
        check("reset frame_done", int'(frame_done), 0);
        check("reset frame_err", int'(frame_err), 0);
        check("reset overrun", int'(overrun), 0);
        check("reset rd_data", int'(rd_data), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);

        rx_wire = 1'b0;
        repeat (5) @(negedge sys_clk);
        rx_wire = 1'b1;
        repeat (40) @(negedge sys_clk);
        check("short pulse state", int'(state), 0);

        for (int i = 0; i < FLEN; i++) send_byte(8'(i % 256), 1'b1, 1'b0);
        check_frame("ramp");
        read_chk(FLEN, 0, "ramp oob");
        read_chk(1023, 0, "ramp oob");

        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, 1'b0);
        check("overrun set", int'(overrun), int'(ovr_exp));
        check_frame("overrun");
        pulse_ack();
        check("ack overrun", int'(overrun), int'(ovr_exp));
        check("ack frame_valid", int'(frame_valid), 0);
        check("ack state", int'(state), 0);

        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1, 1'b0);
        check("partial state", int'(state), 1);
        model_gap();
        repeat (GAP + 400) @(negedge sys_clk);
        check("gap state", int'(state), 0);
        send_random_frame();
        check_frame("after gap");

        pulse_ack();
        send_byte(8'h55, 1'b0, 1'b0);
        check("stop err state", int'(state), 0);
        send_random_frame();
        check_frame("after stop err");

        pulse_ack();
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b1, 1'b0);
        @(negedge sys_clk);
        rst_n = 1'b0;
        cur_q.delete();
        held    = 1'b0;
        ovr_exp = 1'b0;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        check("mid reset state", int'(state), 0);
        send_random_frame();
        check_frame("after reset");

`ifdef RX_GLITCH_FILTER_EN
        pulse_ack();
        send_byte(8'hA5, 1'b1, 1'b1);
        for (int i = 1; i < FLEN; i++) send_byte(8'($urandom), 1'b1, 1'b1);
        check_frame("glitch");
`endif

        repeat (50) @(negedge sys_clk);
        check("events outstanding", exp_ev.size(), 0);
        check("final overrun", int'(overrun), int'(ovr_exp));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
